// File: rtl/pll_ce_pkg.sv
// pll_ce_pkg: shared FSM type and reset-increment helpers for the PLL clock-enable generator.
package pll_ce_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam int MAX_CH    = 8;
    localparam int MAX_ACC_W = 64;
    localparam int VEC_W     = MAX_CH * MAX_ACC_W;

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Extracts channel ch's w-bit field from the packed reset-increment vector.
    function automatic logic [MAX_ACC_W-1:0] inc_slice(
        input logic [VEC_W-1:0] vec,
        input int               ch,
        input int               w
    );
        logic [MAX_ACC_W-1:0] mask;
        mask = (w >= MAX_ACC_W) ? '1 : ((MAX_ACC_W'(1) << w) - MAX_ACC_W'(1));
        return MAX_ACC_W'(vec >> (ch * w)) & mask;
    endfunction

endpackage

// File: rtl/pll_ce_nco.sv
// pll_ce_nco: single-channel phase accumulator; the accumulate carry becomes a registered enable pulse.
module pll_ce_nco #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clear,
    input  logic [ACC_W-1:0] inc,
    output logic             ce
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ce_q, ce_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, inc};
        acc_d = clear ? '0 : run ? sum[ACC_W-1:0] : acc_q;
        ce_d  = !clear && run && sum[ACC_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/pll_ce_gen.sv
// pll_ce_gen: multi-channel fractional clock-enable generator gated by a synchronised, settled PLL lock.
module pll_ce_gen
    import pll_ce_pkg::*;
#(
    parameter int                      NUM_CH        = 2,
    parameter int                      ACC_W         = 32,
    parameter int                      SETTLE_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INC_RESET     = {NUM_CH{32'h2000_0000}},
    localparam int                     CH_W          = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              cfg_resync,
    output logic [NUM_CH-1:0] ce,
    output logic              running
);

    localparam int               CNT_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] INC_VEC = VEC_W'(INC_RESET);

    logic             sync1_q, lock_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cfg_ready_q;
    logic             wr, resync, run;

    assign wr     = cfg_valid && cfg_ready_q;
    assign resync = wr && cfg_resync;
    // Losing lock while in RUN stops accumulation on the same edge the FSM leaves RUN.
    assign run    = (state_q == RUN) && lock_s_q;

    always_comb begin
        state_d = !lock_s_q ? WAIT_LOCK
                : (state_q == SETTLE) ? ((cnt_q == LAST) ? RUN : SETTLE)
                : (state_q == RUN) ? RUN : SETTLE;
        cnt_d   = (state_q == SETTLE) ? cnt_q + CNT_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b0;
        end else begin
            sync1_q     <= pll_locked;
            lock_s_q    <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_ready_q <= 1'b1;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign running   = (state_q == RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [ACC_W-1:0] INC_RST = ACC_W'(inc_slice(INC_VEC, i, ACC_W));
        logic [ACC_W-1:0] inc_q;
        // Channel indices beyond NUM_CH match no channel, so such writes are dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                inc_q <= INC_RST;
            else if (wr && cfg_ch == CH_W'(i))
                inc_q <= cfg_inc;
        end
        pll_ce_nco #(.ACC_W(ACC_W)) u_nco (
            .clk   (clk),
            .rst_n (rst_n),
            .run   (run),
            .clear (resync || !run),
            .inc   (inc_q),
            .ce    (ce[i])
        );
    end

endmodule

// File: tb/tb_pll_ce_gen.sv
// tb_pll_ce_gen: directed self-checking bench for pll_ce_gen (2 channels, 32-bit accumulators, 16-cycle settle).
module tb_pll_ce_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_locked = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_resync = 1'b0;
    logic [0:0]  cfg_ch = '0;
    logic [31:0] cfg_inc = '0;
    logic        cfg_ready, running;
    logic [1:0]  ce;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    pll_ce_gen #(
        .NUM_CH        (2),
        .ACC_W         (32),
        .SETTLE_CYCLES (16),
        .INC_RESET     ({32'h2000_0000, 32'h2000_0000})
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_resync (cfg_resync),
        .ce         (ce),
        .running    (running)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write(input logic ch, input logic [31:0] inc, input logic rs);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_inc    = inc;
        cfg_resync = rs;
        step();
        cfg_valid  = 1'b0;
        cfg_resync = 1'b0;
    endtask

    task automatic wait_run(output int n, output logic [1:0] seen);
        n    = 0;
        seen = '0;
        while (!running && n < 100) begin
            step();
            n++;
            seen |= ce;
        end
    endtask

    // Bit j of h0/h1 holds ce[0]/ce[1] sampled after the (j+1)-th edge.
    task automatic record(input int len, output logic [15:0] h0, output logic [15:0] h1);
        h0 = '0;
        h1 = '0;
        for (int j = 0; j < len; j++) begin
            step();
            h0[j] = ce[0];
            h1[j] = ce[1];
        end
    endtask

    initial begin
        int         n, c0, c1;
        logic [1:0] seen;
        logic [15:0] h0, h1;
        logic       dbl, prev;

        @(negedge clk);
        chk("rst_ce", 32'(ce), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_cfg_ready", 32'(cfg_ready), 0);
        rst_n = 1'b1;
        step();
        chk("cfg_ready_after_release", 32'(cfg_ready), 1);

        write(1'b0, 32'h4000_0000, 1'b0);
        write(1'b1, 32'h8000_0000, 1'b0);

        // Sampling edge + second sync flop + SETTLE entry edge + 16 settle cycles.
        pll_locked = 1'b1;
        wait_run(n, seen);
        chk("lock_delay", n, 19);
        chk("ce_before_run", 32'(seen), 0);

        record(8, h0, h1);
        chk("rate_first_ch0", 32'(h0[7:0]), 32'h88);
        chk("rate_first_ch1", 32'(h1[7:0]), 32'hAA);

        c0 = 0;
        c1 = 0;
        for (int j = 0; j < 1000; j++) begin
            step();
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
        end
        chk("rate_1000_ch0", c0, 250);
        chk("rate_1000_ch1", c1, 500);

        write(1'b0, 32'h5555_5555, 1'b0);
        c0   = 0;
        c1   = 0;
        dbl  = 1'b0;
        prev = 1'b0;
        for (int j = 0; j < 3000; j++) begin
            step();
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
            dbl |= prev && ce[0];
            prev = ce[0];
        end
        chk("frac_count_in_range", 32'((c0 == 999) || (c0 == 1000)), 1);
        chk("frac_no_consecutive", 32'(dbl), 0);
        chk("frac_ch1_unaffected", c1, 1500);

        write(1'b0, 32'h4000_0000, 1'b1);
        chk("resync_cycle_ce", 32'(ce), 0);
        record(8, h0, h1);
        chk("resync_align_ch0", 32'(h0[7:0]), 32'h88);
        chk("resync_align_ch1", 32'(h1[7:0]), 32'hAA);

        // Write edge still accumulates with the old increment (acc1 0 -> 0x8000_0000).
        write(1'b1, 32'h2000_0000, 1'b0);
        record(16, h0, h1);
        chk("reprog_ch0", 32'(h0), 32'h4444);
        chk("reprog_ch1", 32'(h1), 32'h0808);

        pll_locked = 1'b0;
        step();
        chk("lockloss_hold1", 32'(running), 1);
        step();
        chk("lockloss_hold2", 32'(running), 1);
        write(1'b0, 32'h8000_0000, 1'b0);
        chk("lockloss_running", 32'(running), 0);
        chk("lockloss_ce", 32'(ce), 0);
        seen = '0;
        for (int j = 0; j < 20; j++) begin
            step();
            seen |= ce;
        end
        chk("lockloss_ce_quiet", 32'(seen), 0);

        pll_locked = 1'b1;
        wait_run(n, seen);
        chk("relock_delay", n, 19);
        chk("relock_ce_before_run", 32'(seen), 0);
        record(8, h0, h1);
        chk("relock_ch0_write_kept", 32'(h0[7:0]), 32'hAA);
        chk("relock_ch1", 32'(h1[7:0]), 32'h80);

        write(1'b1, 32'h0, 1'b0);
        c1 = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            c1 += int'(ce[1]);
        end
        chk("zero_inc_no_pulse", c1, 0);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ce", 32'(ce), 0);
        chk("async_rst_running", 32'(running), 0);
        chk("async_rst_cfg_ready", 32'(cfg_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_run(n, seen);
        chk("reset_relock_delay", n, 19);
        record(8, h0, h1);
        chk("reset_inc_ch0", 32'(h0[7:0]), 32'h80);
        chk("reset_inc_ch1", 32'(h1[7:0]), 32'h80);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
